p_capture: RTL and testbench

P_CAPTURE -- requirements
Module: p_capture

---
 rtl/dsp48a1_pkg.sv | 19 +
 rtl/p_capture_if.sv | 33 +++
 rtl/p_capture_fifo.sv | 76 +++++++
 rtl/p_capture.sv | 92 +++++++++
 tb/tb_p_capture.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp48a1_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dsp48a1_pkg
// Purpose  : Shared constants for logic that sits around a DSP48A1 slice.
// Revision : 1.0 - initial release
// ============================================================================
package dsp48a1_pkg;

  // Width of the DSP48A1 P result bus
  localparam int P_WIDTH = 48;

  // Default number of CE-enabled pipeline edges from operand issue to valid P
  localparam int DEFAULT_LATENCY = 4;

  // A captured result is {CARRYOUT, P}
  localparam int ENTRY_WIDTH = P_WIDTH + 1;

endpackage
`default_nettype wire

// File: rtl/p_capture_if.sv
`default_nettype none
// ============================================================================
// Interface : p_capture_if
// Purpose   : Result stream from the capture FIFO to the downstream consumer
//             (valid/ready handshake carrying {CARRYOUT, P}).
// Revision  : 1.0 - initial release
// ============================================================================
interface p_capture_if
  import dsp48a1_pkg::*;
#(
  parameter int DWIDTH = ENTRY_WIDTH
);

  logic              res_valid;
  logic              res_ready;
  logic [DWIDTH-1:0] res_data;

  // Producer side: the capture block
  modport master (
    output res_valid,
    output res_data,
    input  res_ready
  );

  // Consumer side
  modport slave (
    input  res_valid,
    input  res_data,
    output res_ready
  );

endinterface
`default_nettype wire

// File: rtl/p_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : p_capture_fifo
// Purpose  : First-word-fall-through result FIFO. Head entry is presented
//            combinationally from storage; a write is never bypassed to the
//            read port in the same cycle. Storage itself is not reset.
// Revision : 1.0 - initial release
// ============================================================================
module p_capture_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     wr_en,
  input  wire logic [WIDTH-1:0]         wr_data,
  input  wire logic                     rd_en,
  output logic      [WIDTH-1:0]         rd_data,
  output logic                          valid,
  output logic                          full,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  // Status and qualified handshakes; a pop on empty is ignored, and a push
  // while full is only accepted when a pop frees a slot on the same edge.
  always_comb begin
    empty   = (occ == '0);
    full    = (occ == (AW + 1)'(DEPTH));
    do_pop  = rd_en & ~empty;
    do_push = wr_en & (~full | do_pop);
    valid   = ~empty;
    rd_data = empty ? '0 : mem[rd_ptr];
    count   = occ;
  end

  // Storage write; no reset needed since occupancy gates what is visible
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two) and occupancy tracks
  // push minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/p_capture.sv
`default_nettype none
// ============================================================================
// Module   : p_capture
// Purpose  : Tracks operands issued into a DSP48A1 pipeline with a CE-gated
//            token delay line and captures {CARRYOUT, P} into a FIFO when
//            the matching result emerges. Drops on a full FIFO are flagged
//            by a sticky overflow bit.
// Revision : 1.0 - initial release
// ============================================================================
module p_capture
  import dsp48a1_pkg::*;
#(
  parameter int PWIDTH  = P_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   ce,
  input  wire logic                   issue,
  input  wire logic [PWIDTH-1:0]      P,
  input  wire logic                   CARRYOUT,
  input  wire logic                   clr_ovf,
  p_capture_if.master                 res,
  output logic      [$clog2(DEPTH):0] count,
  output logic                        overflow
);

  logic strobe;
  logic full;
  logic pop;
  logic drop;
  logic wr_en;

  generate
    if (LATENCY == 0) begin : g_lat_zero
      // Result is combinationally available in the issue cycle
      assign strobe = ce & issue;
    end else begin : g_token_line
      logic [LATENCY-1:0] token;

      // Token line advances only with the DSP clock enable; the oldest
      // token falls off the end on the edge it is captured.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          token <= '0;
        end else if (ce) begin
          token <= LATENCY'({token, issue});
        end
      end

      assign strobe = ce & token[LATENCY-1];
    end
  endgenerate

  // A capture is dropped only when the FIFO is full and nothing leaves it
  // on the same edge. The pop term uses registered res_valid, so res_ready
  // reaches outputs only through state.
  always_comb begin
    pop   = res.res_valid & res.res_ready;
    drop  = strobe & full & ~pop;
    wr_en = strobe & ~drop;
  end

  p_capture_fifo #(
    .WIDTH (PWIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({CARRYOUT, P}),
    .rd_en   (res.res_ready),
    .rd_data (res.res_data),
    .valid   (res.res_valid),
    .full    (full),
    .count   (count)
  );

  // Sticky overflow; a drop on the same edge as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_p_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_capture
// Purpose  : Self-checking bench for p_capture. A LATENCY=4 instance is
//            compared against a countdown/queue reference model; a LATENCY=0
//            instance covers same-cycle capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_p_capture;
  import dsp48a1_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int PW    = P_WIDTH;

  typedef logic [PW:0] e_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          ce        = 1'b0;
  logic          issue     = 1'b0;
  logic [PW-1:0] P         = '0;
  logic          CARRYOUT  = 1'b0;
  logic          res_ready = 1'b0;
  logic          clr_ovf   = 1'b0;
  logic [2:0]    count;
  logic          overflow;
  logic [2:0]    count0;
  logic          overflow0;

  p_capture_if #(.DWIDTH(PW + 1)) rif ();
  p_capture_if #(.DWIDTH(PW + 1)) rif0 ();

  assign rif.res_ready  = res_ready;
  assign rif0.res_ready = res_ready;

  p_capture #(.PWIDTH(PW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .issue(issue), .P(P), .CARRYOUT(CARRYOUT),
    .clr_ovf(clr_ovf), .res(rif.master), .count(count), .overflow(overflow)
  );

  p_capture #(.PWIDTH(PW), .LATENCY(0), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .issue(issue), .P(P), .CARRYOUT(CARRYOUT),
    .clr_ovf(clr_ovf), .res(rif0.master), .count(count0), .overflow(overflow0)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each in-flight operation counts down the CE edges it
  // still needs; the FIFO is a plain queue.
  e_t fq[$];
  int pend[$];
  bit m_ovf;

  function automatic e_t exp_data();
    return (fq.size() != 0) ? fq[0] : '0;
  endfunction

  task automatic model_reset();
    fq.delete();
    pend.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit cap;
    bit pop;
    bit drp;
    cap = 1'b0;
    pop = (fq.size() != 0) && res_ready;
    if (ce) begin
      foreach (pend[i]) pend[i] = pend[i] - 1;
      if (pend.size() != 0 && pend[0] == 0) begin
        void'(pend.pop_front());
        cap = 1'b1;
      end
      if (issue) begin
        if (LAT == 0) cap = 1'b1;
        else pend.push_back(LAT);
      end
    end
    drp = cap && (fq.size() == DEPTH) && !pop;
    if (pop) void'(fq.pop_front());
    if (cap && !drp) fq.push_back({CARRYOUT, P});
    if (drp) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model on the
  // rising edge, return at the next falling edge for sampling.
  task automatic cycle(input bit c, input bit is, input logic [PW-1:0] p,
                       input bit cy, input bit rdy, input bit clr);
    ce = c; issue = is; P = p; CARRYOUT = cy; res_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ce = 0; issue = 0; P = '0; CARRYOUT = 0; res_ready = 0; clr_ovf = 0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++;
    if (rif.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rif.res_valid); end
    n_tests++;
    if (rif.res_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rif.res_data); end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    cycle(1, 1, '0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, (i == 4) ? 48'h0000_0000_1234 : 48'h0, 0, 0, 0);
      if (i == 3) begin
        n_tests++;
        if (rif.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", rif.res_valid); end
      end
    end
    n_tests++;
    if (rif.res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rif.res_valid); end
    n_tests++;
    if (rif.res_data !== 49'h0_0000_0000_1234) begin
      n_fail++; $display("FAIL single_data: got %h want 0000000001234", rif.res_data);
    end
    cycle(1, 0, '0, 0, 1, 0);
    n_tests++;
    if (count !== 3'(fq.size()) || count !== 3'd0) begin n_fail++; $display("FAIL single_drain: got %0d want 0", count); end
  endtask

  task automatic test_ce_stall();
    cycle(1, 1, '0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      cycle(!(k >= 2 && k <= 4), 0, 48'(k), 0, 0, 0);
      n_tests++;
      if (count !== ((k < 7) ? 3'd0 : 3'd1)) begin
        n_fail++; $display("FAIL stall_count_k%0d: got %0d want %0d", k, count, (k < 7) ? 0 : 1);
      end
    end
    n_tests++;
    if (rif.res_data !== 49'd7) begin n_fail++; $display("FAIL stall_data: got %h want 7", rif.res_data); end
    cycle(1, 0, '0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    e_t exp_q[4];
    for (int c = 0; c <= 8; c++) begin
      cycle(1, c <= 4, (c >= 4) ? 48'(c - 3) : 48'h0, 0, 0, 0);
    end
    n_tests++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_tests++;
    if (rif.res_data !== 49'd1) begin n_fail++; $display("FAIL ovf_head: got %h want 1", rif.res_data); end
    cycle(1, 0, '0, 0, 0, 1);
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    // Full FIFO: capture of 9 coincides with a pop
    for (int j = 0; j <= 4; j++) begin
      cycle(1, j == 0, (j == 4) ? 48'd9 : 48'd0, 0, j == 4, 0);
    end
    n_tests++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count: got %0d want 4", count); end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    exp_q = '{49'd2, 49'd3, 49'd4, 49'd9};
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rif.res_data !== exp_q[i] || rif.res_data !== exp_data()) begin
        n_fail++; $display("FAIL drain_%0d: got %h want %h", i, rif.res_data, exp_q[i]);
      end
      cycle(1, 0, '0, 0, 1, 0);
    end
    n_tests++;
    if (rif.res_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", rif.res_valid); end
  endtask

  task automatic test_latency0();
    do_reset();
    cycle(1, 1, 48'd7, 1, 1, 0);
    n_tests++;
    if (count0 !== 3'd1) begin n_fail++; $display("FAIL lat0_count: got %0d want 1", count0); end
    n_tests++;
    if (rif0.res_data !== 49'h1_0000_0000_0007) begin
      n_fail++; $display("FAIL lat0_data: got %h want 1000000000007", rif0.res_data);
    end
    cycle(1, 1, 48'd8, 0, 1, 0);
    n_tests++;
    if (count0 !== 3'd1 || rif0.res_data !== 49'd8) begin
      n_fail++; $display("FAIL lat0_pushpop: got %0d/%h want 1/8", count0, rif0.res_data);
    end
    cycle(0, 1, 48'd5, 0, 1, 0);
    n_tests++;
    if (count0 !== 3'd0 || rif0.res_data !== '0) begin
      n_fail++; $display("FAIL lat0_ce_off: got %0d/%h want 0/0", count0, rif0.res_data);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int k = 0; k <= 7; k++) begin
      cycle(1, (k <= 2) || (k >= 6), 48'(k + 1), 0, 0, 0);
    end
    n_tests++;
    if (count !== 3'd3 || count !== 3'(fq.size())) begin
      n_fail++; $display("FAIL inflight_setup: got %0d want 3", count);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (count !== 3'd0 || rif.res_valid !== 1'b0 || rif.res_data !== '0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got cnt=%0d v=%b d=%h o=%b want all 0",
                         count, rif.res_valid, rif.res_data, overflow);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, 48'hABCD + 48'(k), 0, 0, 0);
      n_tests++;
      if (count !== 3'd0) begin n_fail++; $display("FAIL post_reset_k%0d: got %0d want 0", k, count); end
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = {$urandom, $urandom};
      cycle(($urandom % 4) != 0, $urandom % 2, r[PW-1:0], r[63],
            ($urandom % 3) == 0, ($urandom % 8) == 0);
      n_tests++;
      if (count !== 3'(fq.size())) begin
        n_fail++; $display("FAIL rand_count_%0d: got %0d want %0d", n, count, fq.size());
      end
      n_tests++;
      if (rif.res_valid !== (fq.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid_%0d: got %b want %b", n, rif.res_valid, fq.size() != 0);
      end
      n_tests++;
      if (rif.res_data !== exp_data()) begin
        n_fail++; $display("FAIL rand_data_%0d: got %h want %h", n, rif.res_data, exp_data());
      end
      n_tests++;
      if (overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_ovf_%0d: got %b want %b", n, overflow, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ce_stall();
    test_overflow();
    test_latency0();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
